// File: rtl/regbank_pkg.sv
// regbank_pkg: op encodings and default geometry shared by the register bank and controller
package regbank_pkg;
  localparam int RB_WIDTH = 8;
  localparam int RB_DEPTH = 4;
  localparam int RB_ADDR_W = 2;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;
endpackage

// File: rtl/regbank_op.sv
// regbank_op: combinational in-place modifier (inc/dec/shl) with carry and zero results
module regbank_op import regbank_pkg::*; #(
  parameter int WIDTH = RB_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);
  always_comb begin
    result = op == OP_INC ? value + WIDTH'(1) :
             op == OP_DEC ? value - WIDTH'(1) :
             op == OP_SHL ? {value[WIDTH-2:0], 1'b0} : value;
    carry  = op == OP_INC ? &value :
             op == OP_DEC ? ~|value :
             op == OP_SHL ? value[WIDTH-1] : 1'b0;
    zero   = ~|result;
  end
endmodule

// File: rtl/regbank.sv
// regbank: DEPTH x WIDTH register bank with bus/ALU read ports, in-place ops and Z/C flags
module regbank import regbank_pkg::*; #(
  parameter int WIDTH  = RB_WIDTH,
  parameter int DEPTH  = RB_DEPTH,
  parameter int ADDR_W = RB_ADDR_W
) (
  input  logic              CLK,
  input  logic              nCLR,
  input  logic              nL,
  input  logic              nE,
  input  logic [1:0]        OP,
  input  logic [ADDR_W-1:0] WSEL,
  input  logic [ADDR_W-1:0] RSEL,
  input  logic [ADDR_W-1:0] ASEL,
  input  logic [ADDR_W-1:0] BSEL,
  input  logic [WIDTH-1:0]  DBUS,
  output logic [WIDTH-1:0]  BUSOUT,
  output logic              BUSOE,
  output logic [WIDTH-1:0]  ALUA,
  output logic [WIDTH-1:0]  ALUB,
  output logic              Z,
  output logic              C
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] bus_val, cur, res;
  logic             w_ok, res_c, res_z;
  // Unmatched selects fall through to zero, so out-of-range reads return 0 and writes are dropped
  always_comb begin
    bus_val = '0;
    ALUA = '0;
    ALUB = '0;
    cur = '0;
    w_ok = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus_val = RSEL == ADDR_W'(i) ? regs[i] : bus_val;
      ALUA = ASEL == ADDR_W'(i) ? regs[i] : ALUA;
      ALUB = BSEL == ADDR_W'(i) ? regs[i] : ALUB;
      cur = WSEL == ADDR_W'(i) ? regs[i] : cur;
      w_ok = w_ok | (WSEL == ADDR_W'(i));
    end
  end
  assign BUSOUT = nE ? '0 : bus_val;
  assign BUSOE = !nE;
  regbank_op #(.WIDTH(WIDTH)) u_op (
    .value (cur),
    .op    (OP),
    .result(res),
    .carry (res_c),
    .zero  (res_z)
  );
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      Z <= 1'b0;
      C <= 1'b0;
    end else if (w_ok && (!nL || OP != OP_NOP)) begin
      for (int i = 0; i < DEPTH; i++) if (WSEL == ADDR_W'(i)) regs[i] <= nL ? res : DBUS;
      Z <= nL ? res_z : ~|DBUS;
      if (nL) C <= res_c;
    end
  end
endmodule

// File: tb/tb_regbank.sv
// tb_regbank: directed vector table plus hand sequences for reset, priority and out-of-range cases
module tb_regbank;
  import regbank_pkg::*;
  logic       CLK = 1'b0, nCLR = 1'b0, nL = 1'b1, nE = 1'b1;
  logic [1:0] OP = OP_NOP, WSEL = '0, RSEL = '0, ASEL = '0, BSEL = '0;
  logic [7:0] DBUS = '0;
  logic [7:0] bus4, a4, b4, bus3, a3, b3;
  logic       oe4, z4, c4, oe3, z3, c3;
  int checks = 0, failures = 0;

  regbank #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u4 (
    .CLK(CLK), .nCLR(nCLR), .nL(nL), .nE(nE), .OP(OP), .WSEL(WSEL), .RSEL(RSEL),
    .ASEL(ASEL), .BSEL(BSEL), .DBUS(DBUS), .BUSOUT(bus4), .BUSOE(oe4),
    .ALUA(a4), .ALUB(b4), .Z(z4), .C(c4));
  regbank #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) u3 (
    .CLK(CLK), .nCLR(nCLR), .nL(nL), .nE(nE), .OP(OP), .WSEL(WSEL), .RSEL(RSEL),
    .ASEL(ASEL), .BSEL(BSEL), .DBUS(DBUS), .BUSOUT(bus3), .BUSOE(oe3),
    .ALUA(a3), .ALUB(b3), .Z(z3), .C(c3));

  always #5 CLK = ~CLK;

  typedef struct {
    logic nl, ne;
    logic [1:0] op, ws, rs, as, bs;
    logic [7:0] db, bus, a, b;
    logic z, c;
  } vec_t;
  vec_t v[14];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic nl, input logic [1:0] op, input logic [1:0] ws, input logic [7:0] db);
    nL = nl;
    OP = op;
    WSEL = ws;
    DBUS = db;
  endtask

  initial begin
    v[0]  = '{1'b0, 1'b0, OP_NOP, 2'd2, 2'd2, 2'd2, 2'd0, 8'h3C, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0};
    v[1]  = '{1'b1, 1'b1, OP_NOP, 2'd2, 2'd2, 2'd2, 2'd2, 8'h00, 8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0};
    v[2]  = '{1'b0, 1'b0, OP_NOP, 2'd1, 2'd1, 2'd1, 2'd2, 8'hFF, 8'hFF, 8'hFF, 8'h3C, 1'b0, 1'b0};
    v[3]  = '{1'b1, 1'b0, OP_INC, 2'd1, 2'd1, 2'd1, 2'd2, 8'h00, 8'h00, 8'h00, 8'h3C, 1'b1, 1'b1};
    v[4]  = '{1'b1, 1'b0, OP_INC, 2'd1, 2'd1, 2'd1, 2'd2, 8'h00, 8'h01, 8'h01, 8'h3C, 1'b0, 1'b0};
    v[5]  = '{1'b1, 1'b0, OP_DEC, 2'd0, 2'd0, 2'd0, 2'd1, 8'h00, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1};
    v[6]  = '{1'b1, 1'b0, OP_SHL, 2'd0, 2'd0, 2'd0, 2'd1, 8'h00, 8'hFE, 8'hFE, 8'h01, 1'b0, 1'b1};
    v[7]  = '{1'b0, 1'b0, OP_NOP, 2'd0, 2'd0, 2'd0, 2'd1, 8'h40, 8'h40, 8'h40, 8'h01, 1'b0, 1'b1};
    v[8]  = '{1'b1, 1'b0, OP_SHL, 2'd0, 2'd0, 2'd0, 2'd1, 8'h00, 8'h80, 8'h80, 8'h01, 1'b0, 1'b0};
    v[9]  = '{1'b1, 1'b0, OP_SHL, 2'd0, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1};
    v[10] = '{1'b0, 1'b0, OP_NOP, 2'd3, 2'd3, 2'd3, 2'd0, 8'h07, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1};
    v[11] = '{1'b1, 1'b0, OP_NOP, 2'd3, 2'd3, 2'd2, 2'd1, 8'h55, 8'h07, 8'h3C, 8'h01, 1'b0, 1'b1};
    v[12] = '{1'b1, 1'b0, OP_DEC, 2'd1, 2'd1, 2'd1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h07, 1'b1, 1'b0};
    v[13] = '{1'b0, 1'b0, OP_NOP, 2'd2, 2'd2, 2'd2, 2'd3, 8'h00, 8'h00, 8'h00, 8'h07, 1'b1, 1'b0};

    #3;
    chk("rst_z", {7'd0, z4}, 8'h00);
    chk("rst_c", {7'd0, c4}, 8'h00);
    chk("rst_alua", a4, 8'h00);
    #9 nCLR = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(v[i].nl, v[i].op, v[i].ws, v[i].db);
      nE = v[i].ne;
      RSEL = v[i].rs;
      ASEL = v[i].as;
      BSEL = v[i].bs;
      tick();
      chk($sformatf("vec%0d_bus", i), bus4, v[i].bus);
      chk($sformatf("vec%0d_oe", i), {7'd0, oe4}, {7'd0, !v[i].ne});
      chk($sformatf("vec%0d_a", i), a4, v[i].a);
      chk($sformatf("vec%0d_b", i), b4, v[i].b);
      chk($sformatf("vec%0d_z", i), {7'd0, z4}, {7'd0, v[i].z});
      chk($sformatf("vec%0d_c", i), {7'd0, c4}, {7'd0, v[i].c});
    end

    // load beats INC; same-register read shows old value until the edge
    drive(1'b0, OP_INC, 2'd3, 8'h10);
    RSEL = 2'd3;
    nE = 1'b0;
    #1 chk("prio_old", bus4, 8'h07);
    tick();
    chk("prio_new", bus4, 8'h10);
    chk("prio_z", {7'd0, z4}, 8'h00);
    drive(1'b1, OP_DEC, 2'd0, 8'h00);
    tick();
    chk("pre_rst_c", {7'd0, c4}, 8'h01);

    drive(1'b0, OP_NOP, 2'd1, 8'hA5);
    #2 nCLR = 1'b0;
    #1;
    chk("midrst_z", {7'd0, z4}, 8'h00);
    chk("midrst_c", {7'd0, c4}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      ASEL = 2'(i);
      #1 chk($sformatf("midrst_r%0d", i), a4, 8'h00);
    end
    ASEL = 2'd1;
    tick();
    chk("rst_hold", a4, 8'h00);
    nL = 1'b1;
    #2 nCLR = 1'b1;
    tick();
    chk("post_rst_r1", a4, 8'h00);
    chk("post_rst_z", {7'd0, z4}, 8'h00);

    drive(1'b0, OP_NOP, 2'd0, 8'h11);
    tick();
    drive(1'b0, OP_NOP, 2'd2, 8'h22);
    tick();
    drive(1'b1, OP_DEC, 2'd1, 8'h00);
    tick();
    nL = 1'b1;
    OP = OP_NOP;
    ASEL = 2'd0;
    BSEL = 2'd2;
    #1;
    chk("d3_alua", a3, 8'h11);
    chk("d3_alub", b3, 8'h22);
    chk("d3_c_set", {7'd0, c3}, 8'h01);
    drive(1'b0, OP_NOP, 2'd3, 8'h00);
    tick();
    chk("oor_load_z", {7'd0, z3}, 8'h00);
    chk("oor_load_c", {7'd0, c3}, 8'h01);
    chk("oor_r0", a3, 8'h11);
    chk("oor_r2", b3, 8'h22);
    ASEL = 2'd1;
    #1 chk("oor_r1", a3, 8'hFF);
    drive(1'b1, OP_SHL, 2'd3, 8'h00);
    tick();
    chk("oor_shl_z", {7'd0, z3}, 8'h00);
    chk("oor_shl_c", {7'd0, c3}, 8'h01);
    OP = OP_NOP;
    RSEL = 2'd3;
    ASEL = 2'd3;
    nE = 1'b0;
    #1;
    chk("oor_bus", bus3, 8'h00);
    chk("oor_alua", a3, 8'h00);
    chk("d4_r3", bus4, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
